// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared widths, FSM state type and block type for the dequant stage
// Purpose: common definitions imported by dequant_row and dequant_stage.
// Ports: none (package).
package sys_defs;

  localparam int DQ_IN_W  = 12;  // signed coefficient width from the entropy decoder
  localparam int DQ_Q_W   = 8;   // unsigned quant table entry width
  localparam int DQ_OUT_W = 16;  // signed dequantized output width

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    HOLD
  } dq_state_e;

  // One natural-order 8x8 coefficient block, [row][col].
  typedef logic signed [7:0][7:0][DQ_IN_W-1:0] coef_blk_t;

endpackage

// File: rtl/dequant_row.sv
// rtl/dequant_row.sv - eight combinational dequant multiplier lanes with output fit
// Purpose: res_o[c] = fit(coef_i[c] * q_i[c]) for c = 0..7.
//   fit() saturates when DEQUANT_SAT_EN is defined, otherwise keeps the
//   low OUT_W bits (two's-complement wrap).
// Ports:
//   coef_i  in   [7:0][IN_W-1:0]   signed coefficients of one row
//   q_i     in   [7:0][Q_W-1:0]    unsigned quant entries of the same row
//   res_o   out  [7:0][OUT_W-1:0]  signed dequantized row
module dequant_row
  import sys_defs::*;
#(
  parameter int IN_W  = DQ_IN_W,
  parameter int Q_W   = DQ_Q_W,
  parameter int OUT_W = DQ_OUT_W
) (
  input  logic [7:0][IN_W-1:0]  coef_i,
  input  logic [7:0][Q_W-1:0]   q_i,
  output logic [7:0][OUT_W-1:0] res_o
);

  // Full product width: signed IN_W times a zero-extended (Q_W+1)-bit operand.
  localparam int PW = IN_W + Q_W + 1;

`ifdef DEQUANT_SAT_EN
  localparam logic signed [PW-1:0] MAX_V = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

  for (genvar c = 0; c < 8; c++) begin : g_lane
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;

    // Both operands widened to PW so the multiply is exact at PW bits.
    assign a = {{(PW-IN_W){coef_i[c][IN_W-1]}}, coef_i[c]};
    assign b = {{(PW-Q_W){1'b0}}, q_i[c]};

`ifdef DEQUANT_SAT_EN
    logic signed [PW-1:0] p;
    assign p = a * b;
    assign res_o[c] = (p > MAX_V) ? MAX_V[OUT_W-1:0] :
                      (p < MIN_V) ? MIN_V[OUT_W-1:0] :
                                    p[OUT_W-1:0];
`else
    assign res_o[c] = OUT_W'(a * b);
`endif
  end

endmodule

// File: rtl/dequant_stage.sv
// rtl/dequant_stage.sv - 8x8 block dequantizer between entropy decoder and IDCT
// Purpose: captures one coefficient block, multiplies it row by row with the
//   quant table (one row per cycle) and hands the result to the IDCT with a
//   valid/ready handshake. Blocks arriving while busy are dropped and flagged.
//   Output fit mode selected by macro DEQUANT_SAT_EN (saturate) or wrap.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   block_in   in   [7:0][7:0] signed IN_W coefficients, [row][col]
//   valid_in   in   one-cycle pulse, block_in valid
//   qtab       in   [7:0][7:0] unsigned Q_W quant table, stable during a block
//   block_out  out  [7:0][7:0] signed OUT_W dequantized block
//   valid_out  out  block_out valid
//   ready_in   in   IDCT accepts block_out
//   ready_out  out  stage can accept a block this cycle
//   overrun    out  sticky, a valid_in pulse was dropped
module dequant_stage
  import sys_defs::*;
#(
  parameter int IN_W  = DQ_IN_W,
  parameter int Q_W   = DQ_Q_W,
  parameter int OUT_W = DQ_OUT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [7:0][7:0][IN_W-1:0]    block_in,
  input  logic                                valid_in,
  input  logic        [7:0][7:0][Q_W-1:0]     qtab,
  output logic signed [7:0][7:0][OUT_W-1:0]   block_out,
  output logic                                valid_out,
  input  logic                                ready_in,
  output logic                                ready_out,
  output logic                                overrun
);

  dq_state_e                     state_q, state_d;
  logic [2:0]                    row_cnt_q;
  logic [7:0][7:0][IN_W-1:0]     in_reg_q;
  logic [7:0][7:0][OUT_W-1:0]    out_reg_q;
  logic                          overrun_q;
  logic                          capture;
  logic [7:0][OUT_W-1:0]         row_res;

  // Single row datapath shared across all eight rows, selected by row_cnt.
  dequant_row #(
    .IN_W (IN_W),
    .Q_W  (Q_W),
    .OUT_W(OUT_W)
  ) u_row (
    .coef_i(in_reg_q[row_cnt_q]),
    .q_i   (qtab[row_cnt_q]),
    .res_o (row_res)
  );

  always_comb begin
    state_d   = state_q;
    ready_out = 1'b0;
    valid_out = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          capture = 1'b1;
          state_d = MULT;
        end
      end
      MULT: begin
        if (row_cnt_q == 3'd7) state_d = HOLD;
      end
      HOLD: begin
        valid_out = 1'b1;
        // A new block can be taken in the very cycle the IDCT takes ours.
        ready_out = ready_in;
        if (ready_in) begin
          if (valid_in) begin
            capture = 1'b1;
            state_d = MULT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      in_reg_q  <= '0;
      out_reg_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        in_reg_q  <= block_in;
        row_cnt_q <= '0;
      end else if (state_q == MULT) begin
        out_reg_q[row_cnt_q] <= row_res;
        row_cnt_q            <= row_cnt_q + 3'd1;  // wraps to 0 after row 7
      end
      if (valid_in && !ready_out) overrun_q <= 1'b1;
    end
  end

  assign block_out = out_reg_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dequant_stage.sv
// tb/tb_dequant_stage.sv - scoreboard bench for dequant_stage with randomized traffic
module tb_dequant_stage;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [7:0][7:0][11:0]     block_in;
  logic                      valid_in;
  logic [7:0][7:0][7:0]      qtab;
  logic [7:0][7:0][15:0]     block_out;
  logic                      valid_out;
  logic                      ready_in;
  logic                      ready_out;
  logic                      overrun;

  always #5 clk = ~clk;

  dequant_stage dut (
    .clk      (clk),
    .rst      (rst),
    .block_in (block_in),
    .valid_in (valid_in),
    .qtab     (qtab),
    .block_out(block_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .ready_out(ready_out),
    .overrun  (overrun)
  );

  typedef struct { int v [64]; } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_ovr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference fit on plain integers: clamp or 16-bit two's-complement wrap.
  function automatic int fit(input int p);
`ifdef DEQUANT_SAT_EN
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
`else
    int w;
    w = ((p % 65536) + 65536) % 65536;
    if (w >= 32768) w = w - 65536;
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        block_in[r][c] = 12'($urandom_range(0, 4095));
  endtask

  // Pulse valid_in for one cycle; predict acceptance from ready_out.
  task automatic issue();
    exp_t e;
    int   a;
    int   q;
    valid_in = 1'b1;
    #1;
    if (ready_out) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          a = $signed(block_in[r][c]);
          q = int'(qtab[r][c]);
          e.v[r*8+c] = fit(a * q);
        end
      sb.push_back(e);
    end else begin
      exp_ovr = 1'b1;
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_out && n < 40) begin
      step();
      n++;
    end
  endtask

  // Monitor: every accepted output block is compared against the scoreboard.
  initial begin
    exp_t e;
    int   nbad;
    int   fa;
    int   fe;
    int   fi;
    forever begin
      @(negedge clk);
      if (!rst && valid_out && ready_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_block: got a block, expected none");
        end else begin
          e    = sb.pop_front();
          nbad = 0;
          fa   = 0;
          fe   = 0;
          fi   = 0;
          for (int i = 0; i < 64; i++) begin
            if (int'($signed(block_out[i/8][i%8])) != e.v[i]) begin
              if (nbad == 0) begin
                fa = int'($signed(block_out[i/8][i%8]));
                fe = e.v[i];
                fi = i;
              end
              nbad++;
            end
          end
          if (nbad != 0) begin
            errors++;
            $display("FAIL block_data r%0d c%0d: got %0d expected %0d (%0d bad)",
                     fi / 8, fi % 8, fa, fe, nbad);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0][7:0][15:0] snap;

    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    block_in = '0;
    qtab     = '0;
    exp_ovr  = 1'b0;
    step();
    step();
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ready_out", int'(ready_out), 1);
    chk("rst_block_out_nonzero", int'(block_out != '0), 0);
    rst = 1'b0;
    step();

    // Identity
    ready_in = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        block_in[r][c] = 12'(r*8 + c - 32);
        qtab[r][c]     = 8'd1;
      end
    issue();
    wait_valid(n);
    chk("identity_latency", n, 8);
    step();
    chk("identity_ready_after", int'(ready_out), 1);
    chk("identity_valid_drop", int'(valid_out), 0);

    // Scaling
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        block_in[r][c] = 12'hFFB;  // -5
        qtab[r][c]     = 8'(r + 1);
      end
    issue();
    wait_valid(n);
    chk("scale_row0", int'($signed(block_out[0][3])), -5);
    chk("scale_row7", int'($signed(block_out[7][0])), -40);
    step();

    // Overflow corners
    rand_block();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) qtab[r][c] = 8'd1;
    block_in[0][0] = 12'h7FF;  // 2047
    block_in[0][1] = 12'h800;  // -2048
    qtab[0][0]     = 8'd255;
    qtab[0][1]     = 8'd255;
    issue();
    wait_valid(n);
`ifdef DEQUANT_SAT_EN
    chk("ovf_pos", int'($signed(block_out[0][0])), 32767);
    chk("ovf_neg", int'($signed(block_out[0][1])), -32768);
`else
    chk("ovf_pos", int'($signed(block_out[0][0])), -2303);
    chk("ovf_neg", int'($signed(block_out[0][1])), 2048);
`endif
    step();

    // Fast path: new block offered in the handoff cycle
    rand_block();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) qtab[r][c] = 8'($urandom_range(0, 255));
    issue();
    wait_valid(n);
    chk("fast_first_latency", n, 8);
    rand_block();
    issue();
    chk("fast_valid_low", int'(valid_out), 0);
    wait_valid(n);
    chk("fast_second_latency", n, 8);
    chk("fast_overrun", int'(overrun), 0);
    step();

    // Backpressure with a dropped block inside the window
    ready_in = 1'b0;
    rand_block();
    issue();
    wait_valid(n);
    snap = block_out;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        rand_block();
        issue();
      end else begin
        step();
      end
      chk("bp_valid_held", int'(valid_out), 1);
      chk("bp_block_stable", int'(block_out == snap), 1);
    end
    chk("bp_overrun", int'(overrun), 1);
    ready_in = 1'b1;
    step();
    chk("bp_idle_valid", int'(valid_out), 0);
    chk("bp_idle_ready", int'(ready_out), 1);

    // Randomized traffic and backpressure, fixed table
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) qtab[r][c] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 300; i++) begin
      ready_in = 1'($urandom_range(0, 1));
      rand_block();
      if ($urandom_range(0, 4) == 0) issue();
      else step();
    end
    ready_in = 1'b1;
    repeat (20) step();
    chk("rand_overrun", int'(overrun), int'(exp_ovr));
    chk("rand_drained", sb.size(), 0);

    // Reset in the middle of MULT
    rand_block();
    issue();
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mrst_valid_out", int'(valid_out), 0);
    chk("mrst_overrun", int'(overrun), 0);
    chk("mrst_block_out_nonzero", int'(block_out != '0), 0);
    chk("mrst_ready_out", int'(ready_out), 1);
    sb.delete();
    exp_ovr = 1'b0;
    step();
    rst = 1'b0;
    step();
    rand_block();
    issue();
    wait_valid(n);
    chk("mrst_latency", n, 8);
    repeat (4) step();
    chk("final_drained", sb.size(), 0);
    chk("final_overrun", int'(overrun), int'(exp_ovr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dequant_stage.md
Name: dequant_stage

Overview:
- Sits directly downstream of the entropy decoder, between it and the IDCT.
- Captures one de-zigzagged 8x8 coefficient block and multiplies each coefficient by the matching quantization table entry, processing one row (8 lanes) per cycle.
- Presents the dequantized block to the IDCT with a valid/ready handshake.
- The upstream decoder has no backpressure input, so blocks that arrive while this stage is busy are dropped and flagged.

Parameters:
- IN_W, 12, signed coefficient width from the entropy decoder
- Q_W, 8, unsigned quant table entry width
- OUT_W, 16, signed dequantized output width

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- block_in  input  [7:0][7:0] x IN_W signed  natural-order coefficients, [row][col]
- valid_in  input  1  one-cycle pulse; block_in is valid this cycle
- qtab  input  [7:0][7:0] x Q_W unsigned  natural-order quant table; loaded by the testbench and held stable while a block is processed
- block_out  output  [7:0][7:0] x OUT_W signed  dequantized block
- valid_out  output  1  block_out is valid
- ready_in  input  1  IDCT accepts block_out
- ready_out  output  1  stage can accept a block this cycle
- overrun  output  1  sticky; set when a valid_in pulse is dropped

Behaviour:
- Reset values: block_out all 0, valid_out 0, overrun 0, state IDLE, row_cnt 0, ready_out 1.
- FSM state IDLE:
  - ready_out=1.
  - valid_in=1: register block_in into in_reg, row_cnt<=0, go to MULT.
- FSM state MULT:
  - ready_out=0.
  - Each cycle: out_reg[row_cnt][c] <= fit(in_reg[row_cnt][c] * qtab[row_cnt][c]) for c=0..7; row_cnt++.
  - After row 7, go to HOLD; row_cnt wraps to 0.
- FSM state HOLD:
  - valid_out=1, block_out=out_reg; both held stable while ready_in=0.
  - ready_out = ready_in (combinational).
  - ready_in=1 and valid_in=0: go to IDLE; valid_out drops next cycle.
  - ready_in=1 and valid_in=1 in the same cycle: the handoff completes and the new block is captured; go straight to MULT.
- Arithmetic: signed IN_W x unsigned Q_W, computed as signed (IN_W+Q_W+1) = 21 bits. fit() is defined under Optional Feature.
- Latency: valid_in accepted in cycle T; MULT covers T+1..T+8; valid_out=1 from T+9.
- Throughput: one block per 9 cycles when ready_in is held high (HOLD to MULT fast path).
- Dropped blocks: valid_in while ready_out=0 (MULT, or HOLD with ready_in=0) is ignored and overrun<=1. overrun is cleared only by rst.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); a partially processed block is discarded.
- out_reg rows not yet written keep their values from the previous block; they are not observable because valid_out=0 during MULT.

Optional Feature:
- Macro: DEQUANT_SAT_EN.
- Defined: fit() saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: fit() truncates to the low OUT_W bits (two's-complement wrap). Saves area when table ranges are known safe.

Decomposition:
- Shared package (sys_defs): DQ_IN_W, DQ_Q_W, DQ_OUT_W defaults; a state enum typedef {IDLE, MULT, HOLD}; typedef coef_blk_t for [7:0][7:0] signed IN_W.
- One natural sub-module, dequant_row:
  - Purely combinational: 8 multiplier lanes plus fit().
  - Instantiated once and muxed by row_cnt.
  - The parent holds the FSM, in_reg, out_reg and the handshake logic.

Test Plan:
- Identity: qtab all 1, block_in[r][c]=r*8+c-32, pulse at T with ready_in=1 -> valid_out at T+9, block_out equal to input, ready_out=1 at T+10.
- Scaling: block_in all -5, qtab[r][c]=r+1 -> block_out row r = -5*(r+1); row 7 = -40.
- Overflow:
  - block_in[0][0]=2047, qtab[0][0]=255 -> 32767 with DEQUANT_SAT_EN, -2303 without.
  - block_in[0][1]=-2048, qtab[0][1]=255 -> -32768 with DEQUANT_SAT_EN, 2048 without.
- Backpressure: ready_in low for 5 cycles after valid_out -> block_out stable, valid_out held. A valid_in during that window -> dropped, overrun=1. Raising ready_in -> IDLE next cycle.
- Fast path: valid_in in the same cycle HOLD sees ready_in=1 -> new block captured, valid_out low next cycle, second result 9 cycles later, overrun stays 0.
- Reset in MULT: assert rst at T+4 -> valid_out, overrun, block_out all 0 immediately. A new block after release completes with the normal 9-cycle latency.
